// File: rtl/ysyx_25060170_pipe_skid.sv
// Pipeline register stage with optional 2-entry skid buffer, multi-source
// flush, occupancy reporting and a saturating back-pressure counter.
module ysyx_25060170_pipe_skid #(
  parameter int unsigned WIDTH  = 160,
  parameter int unsigned SKID   = 1,
  parameter int unsigned NFLUSH = 3,
  parameter int unsigned CNTW   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_data,
  input  logic [NFLUSH-1:0] flush,
  output logic [1:0]        occupancy,
  output logic [CNTW-1:0]   stall_cnt
);

  // State encoding doubles as the occupancy count.
  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE   = 2'd1;
  localparam logic [1:0] FULL  = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] skid_q;
  logic             flush_any;
  logic             in_fire;
  logic             out_fire;

  // Handshake decode; with the skid buffer in_ready comes only from state.
  always_comb begin
    flush_any = |flush;
    out_valid = (state != EMPTY);
    if (SKID != 0) begin
      in_ready = (state != FULL);
    end else begin
      in_ready = !out_valid || out_ready;
    end
    in_fire   = in_valid && in_ready;
    out_fire  = out_valid && out_ready;
    out_data  = main_q;
    occupancy = state;
  end

  // Occupancy state machine and payload registers; reset, then flush, win.
  always_ff @(posedge clk) begin
    if (rst || flush_any) begin
      state  <= EMPTY;
      main_q <= '0;
      skid_q <= '0;
    end else begin
      case (state)
        EMPTY: begin
          if (in_fire) begin
            state  <= ONE;
            main_q <= in_data;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            main_q <= in_data;
          end else if (in_fire) begin
            // Only reachable with the skid buffer present: in_ready without
            // out_ready while holding a beat implies SKID != 0.
            if (SKID != 0) begin
              state  <= FULL;
              skid_q <= in_data;
            end
          end else if (out_fire) begin
            state <= EMPTY;
          end
        end
        FULL: begin
          if (out_fire) begin
            state  <= ONE;
            main_q <= skid_q;
          end
        end
        default: begin
          state <= EMPTY;
        end
      endcase
    end
  end

  // Saturating count of cycles where a beat is held but not taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + CNTW'(1);
    end
  end

endmodule

// File: doc/ysyx_25060170_pipe_skid.md
YSYX_25060170_PIPE_SKID -- requirements
Module: ysyx_25060170_pipe_skid

Interface
REQ-001 Parameter WIDTH, default 160, bit width of the payload bundle carried between stages.
REQ-002 Parameter SKID, default 1; 1 selects a 2-entry skid buffer with registered in_ready, 0 selects a 1-entry register with combinational in_ready.
REQ-003 Parameter NFLUSH, default 3, number of independent flush request lines.
REQ-004 Parameter CNTW, default 16, width of the stall counter.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 in_valid  input  1  upstream beat present.
REQ-008 in_ready  output  1  block can accept a beat this cycle.
REQ-009 in_data  input  WIDTH  upstream payload.
REQ-010 out_valid  output  1  downstream beat present.
REQ-011 out_ready  input  1  downstream accepts a beat this cycle.
REQ-012 out_data  output  WIDTH  downstream payload; driven directly from a register.
REQ-013 flush  input  NFLUSH  flush requests, ORed internally.
REQ-014 occupancy  output  2  number of held beats, 0..2.
REQ-015 stall_cnt  output  CNTW  saturating count of back-pressure cycles.

Function
REQ-016 An input beat transfers when in_valid and in_ready are both 1 on a rising edge; an output beat transfers when out_valid and out_ready are both 1.
REQ-017 The block SHALL hold state EMPTY (0 beats), ONE (1 beat, in main register) or FULL (2 beats, main plus skid register; SKID=1 only).
REQ-018 out_valid SHALL be 1 exactly when the state is not EMPTY; out_data SHALL equal the main register.
REQ-019 SKID=1: in_ready SHALL be 1 exactly when the state is not FULL, decoded from registered state only, with no path from out_ready.
REQ-020 SKID=0: in_ready SHALL equal (not out_valid) or out_ready.
REQ-021 EMPTY with input transfer -> ONE, main loads in_data; otherwise stays EMPTY.
REQ-022 ONE with input and output transfer -> ONE, main loads in_data.
REQ-023 ONE with input transfer only -> FULL (SKID=1), skid loads in_data, main unchanged.
REQ-024 ONE with output transfer only -> EMPTY.
REQ-025 FULL with output transfer -> ONE, main loads skid; no input transfer occurs while FULL.
REQ-026 Beats SHALL leave in acceptance order; none lost or duplicated except by flush.
REQ-027 Any flush bit high SHALL force EMPTY next cycle, clear main and skid to zero, and discard any beat accepted in that same cycle; flush has priority over all transfers.
REQ-028 With flush high, in_ready and out_valid SHALL still follow REQ-018..020 for that cycle; a downstream transfer in that cycle completes normally.
REQ-029 occupancy SHALL be 0/1/2 for EMPTY/ONE/FULL.
REQ-030 stall_cnt SHALL increment by 1 each cycle with out_valid=1 and out_ready=0, saturate at all-ones, and be unaffected by flush.
REQ-031 Latency: a beat accepted into EMPTY SHALL appear on out_data one cycle later.
REQ-032 Full throughput: with in_valid and out_ready held 1, one beat per cycle SHALL transfer in both modes.

Reset
REQ-033 While rst=1 on a rising edge: state EMPTY, main and skid zero, stall_cnt zero; rst has priority over flush and transfers.
REQ-034 Reset values: out_valid=0, out_data=0, occupancy=0, stall_cnt=0, in_ready=1.
REQ-035 Reset asserted mid-operation SHALL discard all held beats with no output transfer.

Verification
REQ-036 SKID=1, rst then in_valid=1 data 0x11, out_ready=1 -> out_valid=1, out_data=0x11 next cycle; in_ready stays 1.
REQ-037 SKID=1, out_ready=0, push 0xA then 0xB -> occupancy=2, in_ready=0, out_data=0xA; release out_ready -> 0xA then 0xB, occupancy 2->1->0.
REQ-038 SKID=1 FULL, flush=3'b010 with in_valid=1 -> next cycle out_valid=0, out_data=0, occupancy=0, pushed beat absent from output.
REQ-039 SKID=0, out_ready=0 while ONE -> in_ready=0; out_ready=1 same cycle -> in_ready=1, back-to-back beats 1,2,3 emerge in order.
REQ-040 CNTW=4, out_valid=1, out_ready=0 for 20 cycles -> stall_cnt reaches 15 and holds; rst -> 0.
REQ-041 Random in_valid/out_ready/flush for 10000 cycles in both modes -> output sequence equals scoreboard of accepted, non-flushed beats; occupancy never exceeds 2 (1 for SKID=0).
